mv_field_server: RTL and testbench

MV_FIELD_SERVER -- requirements
Module: mv_field_server

---
 rtl/mv_field_server.sv | 161 ++++++++++++++++
 tb/tb_mv_field_server.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_field_server.sv
// Double-banked motion-vector field server: loads a raw field, serves filter reads,
// collects filtered write-backs in a separate bank and dumps that bank at frame end.
module mv_field_server #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  height,
  input  logic [7:0]  width,
  input  logic        ld_valid,
  input  logic [8:0]  ld_data,
  input  logic [15:0] index,
  input  logic        rd_req,
  output logic [8:0]  data,
  output logic        rd_valid,
  input  logic        swmv,
  input  logic [15:0] wb_index,
  input  logic [8:0]  wb_data,
  input  logic        Gvector_sig,
  output logic        Nxt_block_sig,
  output logic        out_valid,
  output logic [8:0]  out_data,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [8:0]  NULLV   = 9'h100;
  localparam logic [31:0] DEPTH_U = DEPTH;

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DUMP} state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic [15:0] wb_cnt_q, wb_cnt_d;
  logic [15:0] dump_cnt_q, dump_cnt_d;
  logic        pend_q, pend_d;
  logic        nxt_q, nxt_d;
  logic        rd_valid_q, rd_valid_d;
  logic [8:0]  data_q, data_d;
  logic        out_valid_q, out_valid_d;
  logic [8:0]  out_data_q, out_data_d;
  logic        frame_done_q, frame_done_d;

  logic [8:0]  bank_in_q  [DEPTH];
  logic [8:0]  bank_out_q [DEPTH];

  logic ld_acc, ld_we, rd_hit, wb_ok, dump_hit;

  assign ld_acc   = (state_q == LOAD) && (n_q != 16'd0) && ld_valid;
  assign ld_we    = ld_acc && (32'(ld_cnt_q) < DEPTH_U);
  assign rd_hit   = (index < n_q) && (32'(index) < DEPTH_U);
  assign wb_ok    = (state_q == SERVE) && swmv && (wb_index < n_q) && (32'(wb_index) < DEPTH_U);
  assign dump_hit = 32'(dump_cnt_q) < DEPTH_U;

  // Loading also scrubs the matching OUT entry so unwritten vectors dump as NULL.
  always_ff @(posedge CLK) begin
    if (ld_we) begin
      bank_in_q[ld_cnt_q[AW-1:0]]  <= ld_data;
      bank_out_q[ld_cnt_q[AW-1:0]] <= NULLV;
    end
    if (wb_ok) begin
      bank_out_q[wb_index[AW-1:0]] <= wb_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    ld_cnt_d     = ld_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    dump_cnt_d   = dump_cnt_q;
    rd_valid_d   = 1'b0;
    data_d       = data_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    nxt_d        = Gvector_sig && pend_q;
    pend_d       = (pend_q && !Gvector_sig) || wb_ok;
    frame_done_d = out_valid_q && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          n_d        = {8'd0, height} * {8'd0, width};
          ld_cnt_d   = 16'd0;
          wb_cnt_d   = 16'd0;
          dump_cnt_d = 16'd0;
          pend_d     = 1'b0;
        end
      end
      LOAD: begin
        if (n_q == 16'd0) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else if (ld_acc) begin
          ld_cnt_d = ld_cnt_q + 16'd1;
          if (ld_cnt_q + 16'd1 == n_q) state_d = SERVE;
        end
      end
      SERVE: begin
        if (rd_req) begin
          rd_valid_d = 1'b1;
          data_d     = rd_hit ? bank_in_q[index[AW-1:0]] : NULLV;
        end
        if (wb_ok) begin
          wb_cnt_d = wb_cnt_q + 16'd1;
          if (wb_cnt_q + 16'd1 == n_q) state_d = DUMP;
        end
      end
      DUMP: begin
        out_valid_d = 1'b1;
        out_data_d  = dump_hit ? bank_out_q[dump_cnt_q[AW-1:0]] : NULLV;
        dump_cnt_d  = dump_cnt_q + 16'd1;
        if (dump_cnt_q + 16'd1 == n_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      n_q          <= 16'd0;
      ld_cnt_q     <= 16'd0;
      wb_cnt_q     <= 16'd0;
      dump_cnt_q   <= 16'd0;
      pend_q       <= 1'b0;
      nxt_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      data_q       <= 9'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 9'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      ld_cnt_q     <= ld_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      dump_cnt_q   <= dump_cnt_d;
      pend_q       <= pend_d;
      nxt_q        <= nxt_d;
      rd_valid_q   <= rd_valid_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data          = data_q;
  assign rd_valid      = rd_valid_q;
  assign Nxt_block_sig = nxt_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mv_field_server.sv
// Bench for mv_field_server: directed frames, a read-vector table, and random frames
// checked against an array-based model of the IN/OUT banks.
module tb_mv_field_server;

  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam logic [8:0] NUL   = 9'h100;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  height, width;
  logic        ld_valid;
  logic [8:0]  ld_data;
  logic [15:0] index;
  logic        rd_req;
  logic [8:0]  data;
  logic        rd_valid;
  logic        swmv;
  logic [15:0] wb_index;
  logic [8:0]  wb_data;
  logic        Gvector_sig;
  logic        Nxt_block_sig;
  logic        out_valid;
  logic [8:0]  out_data;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: bank images and frame bookkeeping.
  int         n_m;
  int         ldc_m;
  int         wbc_m;
  logic [8:0] in_m  [DEPTH];
  logic [8:0] out_m [DEPTH];

  typedef struct {
    logic [15:0] idx;
    logic [8:0]  exp;
  } rd_vec_t;
  rd_vec_t tbl [7];

  mv_field_server #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .height(height), .width(width),
    .ld_valid(ld_valid), .ld_data(ld_data), .index(index), .rd_req(rd_req),
    .data(data), .rd_valid(rd_valid), .swmv(swmv), .wb_index(wb_index),
    .wb_data(wb_data), .Gvector_sig(Gvector_sig), .Nxt_block_sig(Nxt_block_sig),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; height = 0; width = 0; ld_valid = 0; ld_data = 0;
    index = 0; rd_req = 0; swmv = 0; wb_index = 0; wb_data = 0; Gvector_sig = 0;
  endtask

  function automatic logic [8:0] model_rd(input int idx);
    return (idx < n_m && idx < DEPTH) ? in_m[idx] : NUL;
  endfunction

  task automatic begin_frame(input int h, input int w);
    height = 8'(h);
    width  = 8'(w);
    start  = 1;
    tick();
    start  = 0;
    n_m    = (h * w) & 16'hFFFF;
    ldc_m  = 0;
    wbc_m  = 0;
    for (int i = 0; i < DEPTH; i++) out_m[i] = NUL;
  endtask

  task automatic load(input logic [8:0] v);
    ld_valid = 1;
    ld_data  = v;
    tick();
    ld_valid = 0;
    if (ldc_m < DEPTH) in_m[ldc_m] = v;
    ldc_m++;
  endtask

  // One SERVE cycle with an optional read and an optional write-back.
  task automatic cyc(input bit r, input int ridx, input bit w, input int widx, input logic [8:0] wd);
    logic [8:0] exp_rd;
    exp_rd   = model_rd(ridx);
    rd_req   = r;
    index    = 16'(ridx);
    swmv     = w;
    wb_index = 16'(widx);
    wb_data  = wd;
    tick();
    rd_req = 0;
    swmv   = 0;
    if (r) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk($sformatf("rd_data[%0d]", ridx), 32'(data), 32'(exp_rd));
    end
    if (w && widx < n_m && widx < DEPTH) begin
      out_m[widx] = wd;
      wbc_m++;
    end
  endtask

  task automatic dump_check(input string nm);
    int waited = 0;
    while (!out_valid && waited < 8) begin
      tick();
      waited++;
    end
    if (!out_valid) begin
      chk({nm, "_dump_start"}, 32'(out_valid), 32'd1);
      return;
    end
    for (int i = 0; i < n_m; i++) begin
      chk($sformatf("%s_dump_valid[%0d]", nm, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_dump_data[%0d]", nm, i), 32'(out_data), 32'((i < DEPTH) ? out_m[i] : NUL));
      tick();
    end
    chk({nm, "_frame_done"}, 32'(frame_done), 32'd1);
    chk({nm, "_dump_end"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    tick();
    chk({nm, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  task automatic random_frame(input string nm);
    int h, w, lim, guard, widx;
    h = int'($urandom_range(1, 4));
    w = int'($urandom_range(1, 5));
    begin_frame(h, w);
    for (int i = 0; i < n_m; i++) load(9'($urandom_range(0, 511)));
    lim   = (n_m < DEPTH) ? n_m : DEPTH;
    guard = 0;
    while (wbc_m < n_m && guard < 300) begin
      if ($urandom_range(0, 9) == 0) widx = n_m + int'($urandom_range(0, 2));
      else widx = int'($urandom_range(0, lim - 1));
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, n_m + 3)),
          1'($urandom_range(0, 2) != 0), widx, 9'($urandom_range(0, 511)));
      guard++;
    end
    if (wbc_m < n_m) chk({nm, "_wb_guard"}, 32'(wbc_m), 32'(n_m));
    dump_check(nm);
  endtask

  initial begin
    int pulses;

    tbl[0] = '{16'd4,     9'h004};
    tbl[1] = '{16'd0,     9'h000};
    tbl[2] = '{16'd5,     9'h005};
    tbl[3] = '{16'd6,     9'h100};
    tbl[4] = '{16'hFFFF,  9'h100};
    tbl[5] = '{16'd2,     9'h002};
    tbl[6] = '{16'd16,    9'h100};

    clear_inputs();
    reset = 0;
    #1;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_nxt", 32'(Nxt_block_sig), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    reset = 1;
    tick();

    // Reads and loads in IDLE are ignored.
    rd_req = 1; ld_valid = 1; index = 0;
    tick();
    rd_req = 0; ld_valid = 0;
    chk("idle_rd_ignored", 32'(rd_valid), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Frame A: 2x3, load 0..5 with a stray start and read during LOAD.
    begin_frame(2, 3);
    chk("frameA_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) load(9'(i));
    start = 1; rd_req = 1; index = 0;
    load(9'd3);
    start = 0; rd_req = 0;
    chk("load_rd_ignored", 32'(rd_valid), 32'd0);
    for (int i = 4; i < 6; i++) load(9'(i));

    rd_req = 1;
    for (int i = 0; i < 7; i++) begin
      index = tbl[i].idx;
      tick();
      chk($sformatf("tbl_rd_valid[%0d]", i), 32'(rd_valid), 32'd1);
      chk($sformatf("tbl_rd_data[%0d]", i), 32'(data), 32'(tbl[i].exp));
    end
    rd_req = 0;
    tick();
    chk("rd_single_cycle", 32'(rd_valid), 32'd0);

    // Write-back and release handshake.
    cyc(0, 0, 1, 2, 9'h007);
    pulses = 0;
    Gvector_sig = 1;
    repeat (3) begin tick(); pulses += int'(Nxt_block_sig); end
    Gvector_sig = 0;
    repeat (2) begin tick(); pulses += int'(Nxt_block_sig); end
    chk("nxt_one_pulse", 32'(pulses), 32'd1);
    pulses = 0;
    Gvector_sig = 1;
    repeat (3) begin tick(); pulses += int'(Nxt_block_sig); end
    Gvector_sig = 0;
    chk("nxt_no_repeat", 32'(pulses), 32'd0);
    cyc(1, 2, 0, 0, 9'h000);
    chk("in_unchanged", 32'(data), 32'h002);

    cyc(0, 0, 1, 6, 9'h055);
    cyc(1, 1, 1, 1, 9'h1AB);
    chk("collision_in_value", 32'(data), 32'h001);
    cyc(0, 0, 1, 0, 9'h0A0);
    cyc(0, 0, 1, 3, 9'h0C3);
    cyc(0, 0, 1, 4, 9'h144);
    chk("serve_busy", 32'(busy), 32'd1);
    cyc(0, 0, 1, 2, 9'h033);
    chk("frameA_out1", 32'(out_m[1]), 32'h1AB);
    dump_check("frameA");

    // Same size again: only index 5 written, stale OUT data must be gone.
    begin_frame(3, 2);
    for (int i = 0; i < 6; i++) load(9'(i + 100));
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 5, 9'(i + 1));
    dump_check("frameB");

    // Empty frame.
    begin_frame(0, 5);
    chk("empty_busy", 32'(busy), 32'd1);
    tick();
    chk("empty_frame_done", 32'(frame_done), 32'd1);
    chk("empty_idle", 32'(busy), 32'd0);
    tick();
    chk("empty_frame_done_pulse", 32'(frame_done), 32'd0);

    // Field larger than the bank.
    begin_frame(4, 5);
    for (int i = 0; i < n_m; i++) load(9'($urandom_range(0, 511)));
    cyc(1, 17, 0, 0, 9'h000);
    chk("beyond_depth_null", 32'(data), 32'(NUL));
    for (int i = 0; i < n_m; i++) cyc(0, 0, 1, i % DEPTH, 9'($urandom_range(0, 511)));
    dump_check("big");

    for (int k = 0; k < 3; k++) random_frame($sformatf("rand%0d", k));

    // Reset aborts a frame in LOAD.
    begin_frame(2, 3);
    for (int i = 0; i < 3; i++) load(9'(i + 10));
    #2;
    reset = 0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1;
    tick();
    ld_valid = 1; ld_data = 9'h1FF;
    tick();
    ld_valid = 0;
    chk("abort_needs_start", 32'(busy), 32'd0);
    begin_frame(2, 3);
    for (int i = 0; i < 6; i++) load(9'(i + 20));
    cyc(1, 0, 0, 0, 9'h000);
    cyc(1, 5, 0, 0, 9'h000);
    for (int i = 0; i < 6; i++) cyc(1, 5 - i, 1, i, 9'(i * 7 + 3));
    dump_check("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
